ticket_sequencer: RTL
=====================

Name: ticket_sequencer

Overview:
- Upstream stage of the vending machine refund block. Accepts coins and accumulates them into `cash`. Latches the passenger-type selection and decides when a purchase is paid for.
- Drives the refund stage's interface (`cash`, `block_cash`, `child`/`men`/`women`, `en`) and its own ticket/refund handshake.
- Also handles cancel and inactivity timeout, both of which return the full amount.

Parameters:
- PRICE_CHILD, 8, child ticket price in cash units
- PRICE_MEN, 12, men ticket price
- PRICE_WOMEN, 15, women ticket price
- CASH_MAX, 127, saturation limit of `cash` (7-bit)
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-cancel

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coin_in  in  1  one-cycle pulse: a coin is present
- coin_sel  in  2  coin value: 0→1, 1→2, 2→5, 3→10
- sel_child  in  1  pulse: child ticket selected
- sel_men  in  1  pulse: men ticket selected
- sel_women  in  1  pulse: women ticket selected
- cancel  in  1  pulse: user cancel
- refund_ack  in  1  refund payout complete
- cash  out  7  accumulated cash, to refund stage
- block_cash  out  1  one-cycle pulse: latch ticket price, to refund stage
- child  out  1  latched selection (one-hot with `men`/`women`)
- men  out  1  latched selection
- women  out  1  latched selection
- en  out  1  1 = purchase refund (cash − price); 0 = full refund
- ticket_out  out  1  one-cycle pulse: dispense ticket
- refund_valid  out  1  refund request, held until `refund_ack`
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted

Behaviour:
- Reset (`rst`=0, asynchronous): all outputs 0, state IDLE, timeout counter 0.
- All outputs are registered.
- States: IDLE, COLLECT, BLOCK, VEND, REFUND.
- Coin acceptance (IDLE/COLLECT only):
  - `cash` <= `cash` + value(`coin_sel`).
  - If the sum exceeds CASH_MAX: `cash` unchanged and `coin_reject` pulses next cycle.
  - In BLOCK, VEND and REFUND every `coin_in` is rejected (`coin_reject` pulse, `cash` unchanged).
- Selection latch (IDLE/COLLECT only):
  - Any `sel_*` pulse overwrites the `child`/`men`/`women` one-hot.
  - Simultaneous pulses resolve by priority `child` > `men` > `women`.
  - Selections are ignored in the other states.
- IDLE: an accepted coin moves to COLLECT (`cash` = coin value). A selection alone stays in IDLE but is latched. `cancel` in IDLE is ignored.
- COLLECT evaluation order, using registered `cash`/selection:
  1. `cancel` or timeout → REFUND with `en`=0.
  2. Selection valid and `cash` >= price(selection) → BLOCK.
  3. Otherwise stay.
  - A coin arriving in the cycle that transitions out is still accepted (excess is refunded).
- BLOCK: exactly 1 cycle. `block_cash`=1, selection and `cash` stable. Next state VEND.
- VEND: exactly 1 cycle. `ticket_out`=1, `en`=1. Next state REFUND.
- REFUND:
  - `refund_valid`=1; `en`, `cash` and selection held stable.
  - On `refund_ack`: `cash`<=0, selection cleared, `en`<=0, `refund_valid`<=0, next state IDLE.
  - A zero-change purchase still passes through REFUND (downstream computes 0).
  - An ack outside REFUND is ignored.
- Timeout:
  - Counter runs only in COLLECT; cleared on an accepted coin, a selection, or state entry.
  - When it reaches TIMEOUT_CYCLES−1, treated as `cancel`.
- Latency: selection + sufficient `cash` registered at cycle N → `block_cash` at N+1, `ticket_out` at N+2, `refund_valid` from N+3.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No ticket, no refund request.
- Price comparison is 7-bit unsigned; prices must be ≤ CASH_MAX.

Decomposition:
- Shared package `vm_pkg`:
  - price constants (8/12/15)
  - CASH_W=7 and CASH_MAX
  - coin encoding and coin-value function
  - state enum
  - selection one-hot encoding
- Sub-module `vm_timeout_timer`: parameterised down-counter with clear, enable and expire pulse. Counter width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Reset, then coins 10 + 5, then `sel_men` → `block_cash` 1 cycle with `men`=1, `cash`=15; next cycle `ticket_out`=1, `en`=1; `refund_valid` held until `refund_ack`; then `cash`=0, state IDLE.
- `sel_child` first, then coins 5, 2, 1 → purchase starts only after `cash`=8; `cash` stays 8, downstream refund 0.
- Coins 5 + 2, then `cancel` → no `block_cash`, no `ticket_out`; `refund_valid`=1 with `en`=0, `cash`=7.
- `cash`=120 plus coin 10 → `coin_reject` pulse, `cash` stays 120. A coin during VEND → `coin_reject`, `cash` unchanged.
- `sel_child` and `sel_women` in the same cycle with `cash`=10 → `child`=1 wins, purchase proceeds. Separately, coin 1 then no activity for TIMEOUT_CYCLES → auto full refund (`en`=0).
- Assert `rst`=0 during REFUND → all outputs 0 asynchronously, IDLE. A later `refund_ack` has no effect.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine ticket path: prices, cash width,
// coin encoding, sequencer states and the passenger selection one-hot.
package vm_pkg;

    localparam int CASH_W         = 7;
    localparam int CASH_MAX       = 127;
    localparam int PRICE_CHILD    = 8;
    localparam int PRICE_MEN      = 12;
    localparam int PRICE_WOMEN    = 15;
    localparam int TIMEOUT_CYCLES = 1000;

    typedef enum logic [1:0] {
        COIN_1  = 2'd0,
        COIN_2  = 2'd1,
        COIN_5  = 2'd2,
        COIN_10 = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_BLOCK   = 3'd2,
        ST_VEND    = 3'd3,
        ST_REFUND  = 3'd4
    } state_e;

    // Bit order matches the output ports: {child, men, women}.
    typedef logic [2:0] sel_t;
    localparam sel_t SEL_NONE  = 3'b000;
    localparam sel_t SEL_CHILD = 3'b100;
    localparam sel_t SEL_MEN   = 3'b010;
    localparam sel_t SEL_WOMEN = 3'b001;

    function automatic logic [CASH_W-1:0] coin_value(input logic [1:0] sel);
        logic [CASH_W-1:0] v;
        case (coin_e'(sel))
            COIN_1:  v = CASH_W'(1);
            COIN_2:  v = CASH_W'(2);
            COIN_5:  v = CASH_W'(5);
            default: v = CASH_W'(10);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm_timeout_timer.sv
// Inactivity down-counter: reloads on clear, counts while enabled and flags
// expiry once CYCLES-1 enabled cycles have elapsed since the last clear.
module vm_timeout_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LOAD;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Activity in the same cycle wins over expiry.
    assign expire = enable && !clear && (count_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ticket_sequencer.sv
// Front end of the vending machine refund block: accumulates coins, latches the
// passenger selection and sequences block/vend/refund towards the refund stage.
module ticket_sequencer
    import vm_pkg::*;
#(
    parameter int PRICE_CHILD    = vm_pkg::PRICE_CHILD,
    parameter int PRICE_MEN      = vm_pkg::PRICE_MEN,
    parameter int PRICE_WOMEN    = vm_pkg::PRICE_WOMEN,
    parameter int CASH_MAX       = vm_pkg::CASH_MAX,
    parameter int TIMEOUT_CYCLES = vm_pkg::TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_in,
    input  logic [1:0]        coin_sel,
    input  logic              sel_child,
    input  logic              sel_men,
    input  logic              sel_women,
    input  logic              cancel,
    input  logic              refund_ack,
    output logic [CASH_W-1:0] cash,
    output logic              block_cash,
    output logic              child,
    output logic              men,
    output logic              women,
    output logic              en,
    output logic              ticket_out,
    output logic              refund_valid,
    output logic              coin_reject
);

    localparam logic [CASH_W-1:0] P_CHILD    = CASH_W'(PRICE_CHILD);
    localparam logic [CASH_W-1:0] P_MEN      = CASH_W'(PRICE_MEN);
    localparam logic [CASH_W-1:0] P_WOMEN    = CASH_W'(PRICE_WOMEN);
    localparam logic [CASH_W:0]   CASH_LIMIT = (CASH_W + 1)'(CASH_MAX);

    state_e            state_q, state_d;
    logic [CASH_W-1:0] cash_q, cash_d;
    sel_t              sel_q, sel_d;
    logic              en_q, en_d;
    logic              block_cash_q, block_cash_d;
    logic              ticket_out_q, ticket_out_d;
    logic              refund_valid_q, refund_valid_d;
    logic              coin_reject_q, coin_reject_d;

    logic              accepting;
    logic [CASH_W:0]   coin_sum;
    logic              coin_ok;
    logic              sel_pulse;
    sel_t              sel_new;
    logic [CASH_W-1:0] price;
    logic              paid;
    logic              timer_clear;
    logic              timer_expire;

    always_comb begin
        accepting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
        coin_sum  = {1'b0, cash_q} + {1'b0, coin_value(coin_sel)};
        coin_ok   = coin_in && accepting && (coin_sum <= CASH_LIMIT);

        sel_pulse = sel_child || sel_men || sel_women;
        if (sel_child) begin
            sel_new = SEL_CHILD;
        end else if (sel_men) begin
            sel_new = SEL_MEN;
        end else if (sel_women) begin
            sel_new = SEL_WOMEN;
        end else begin
            sel_new = SEL_NONE;
        end

        if (sel_q[2]) begin
            price = P_CHILD;
        end else if (sel_q[1]) begin
            price = P_MEN;
        end else begin
            price = P_WOMEN;
        end
        paid = (sel_q != SEL_NONE) && (cash_q >= price);
    end

    assign timer_clear = (state_q != ST_COLLECT) || coin_ok || sel_pulse;

    vm_timeout_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (state_q == ST_COLLECT),
        .expire (timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        cash_d         = cash_q;
        sel_d          = sel_q;
        en_d           = en_q;
        block_cash_d   = 1'b0;
        ticket_out_d   = 1'b0;
        refund_valid_d = refund_valid_q;
        coin_reject_d  = coin_in && !coin_ok;

        if (coin_ok) begin
            cash_d = coin_sum[CASH_W-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_pulse) begin
                    sel_d = sel_new;
                end
                if (coin_ok) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Selection is frozen on the exit cycle so BLOCK reports the
                // passenger type the payment was judged against.
                if (cancel || timer_expire) begin
                    state_d        = ST_REFUND;
                    en_d           = 1'b0;
                    refund_valid_d = 1'b1;
                end else if (paid) begin
                    state_d      = ST_BLOCK;
                    block_cash_d = 1'b1;
                end else if (sel_pulse) begin
                    sel_d = sel_new;
                end
            end
            ST_BLOCK: begin
                state_d      = ST_VEND;
                ticket_out_d = 1'b1;
                en_d         = 1'b1;
            end
            ST_VEND: begin
                state_d        = ST_REFUND;
                refund_valid_d = 1'b1;
            end
            ST_REFUND: begin
                if (refund_ack) begin
                    state_d        = ST_IDLE;
                    cash_d         = '0;
                    sel_d          = SEL_NONE;
                    en_d           = 1'b0;
                    refund_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                cash_d         = '0;
                sel_d          = SEL_NONE;
                en_d           = 1'b0;
                refund_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cash_q         <= '0;
            sel_q          <= SEL_NONE;
            en_q           <= 1'b0;
            block_cash_q   <= 1'b0;
            ticket_out_q   <= 1'b0;
            refund_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cash_q         <= cash_d;
            sel_q          <= sel_d;
            en_q           <= en_d;
            block_cash_q   <= block_cash_d;
            ticket_out_q   <= ticket_out_d;
            refund_valid_q <= refund_valid_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign cash         = cash_q;
    assign block_cash   = block_cash_q;
    assign child        = sel_q[2];
    assign men          = sel_q[1];
    assign women        = sel_q[0];
    assign en           = en_q;
    assign ticket_out   = ticket_out_q;
    assign refund_valid = refund_valid_q;
    assign coin_reject  = coin_reject_q;

endmodule
